// File: rtl/song_sequencer.sv
// song_sequencer: upstream stage of the note player.
//
// Walks an external song ROM (synchronous, 1-cycle read). It presents one {note, duration} pair
// at a time with a one-cycle load strobe. It then waits for the note player to report completion
// before it fetches the next entry. It signals end-of-song to the top-level control FSM.
//
// Optional build feature (macro SONG_LOOP_EN):
//   defined   - at end of song, restart from entry 0 if play is high; otherwise go idle
//   undefined - end of song always returns to idle
//
// Ports:
//   clk              in   system clock
//   reset            in   synchronous, active-high reset
//   play             in   1 = may fetch/advance, 0 = hold position
//   song             in   song select
//   note_done        in   completion from the note player (one count per high cycle)
//   rom_addr         out  {song_q, index}, combinational
//   rom_data         in   {note, duration}, valid the cycle after rom_addr
//   note_to_load     out  registered note code
//   duration_to_load out  registered duration
//   load_new_note    out  one-cycle strobe while in the load state
//   song_done        out  one-cycle end-of-song pulse (registered)
module song_sequencer #(
  parameter int unsigned NOTE_W = 6,
  parameter int unsigned DUR_W  = 6,
  parameter int unsigned SONG_W = 2,
  parameter int unsigned IDX_W  = 5
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     play,
  input  logic [SONG_W-1:0]        song,
  input  logic                     note_done,
  output logic [SONG_W+IDX_W-1:0]  rom_addr,
  input  logic [NOTE_W+DUR_W-1:0]  rom_data,
  output logic [NOTE_W-1:0]        note_to_load,
  output logic [DUR_W-1:0]         duration_to_load,
  output logic                     load_new_note,
  output logic                     song_done
);

  typedef enum logic [2:0] {
    StIdle,
    StAddr,
    StData,
    StLoad,
    StWaitDone
  } state_e;

  localparam logic [IDX_W-1:0] LastIdx = '1;

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    index_q, index_d;
  logic [SONG_W-1:0]   song_q, song_d;
  logic                pending_q, pending_d;
  logic [NOTE_W-1:0]   note_q, note_d;
  logic [DUR_W-1:0]    dur_q, dur_d;
  logic                song_done_q, song_done_d;

  logic [NOTE_W-1:0]   rom_note;
  logic [DUR_W-1:0]    rom_dur;
  logic                end_song;

  assign rom_note = rom_data[NOTE_W+DUR_W-1:DUR_W];
  assign rom_dur  = rom_data[DUR_W-1:0];

  always_comb begin
    state_d     = state_q;
    index_d     = index_q;
    song_d      = song_q;
    pending_d   = pending_q;
    note_d      = note_q;
    dur_d       = dur_q;
    song_done_d = 1'b0;
    end_song    = 1'b0;

    if (state_q != StIdle && song != song_q) begin
      // A song change restarts the new song from the top and wins over everything else.
      song_d    = song;
      index_d   = '0;
      pending_d = 1'b0;
      state_d   = StAddr;
    end else begin
      unique case (state_q)
        StIdle: begin
          song_d = song;
          if (play) begin
            state_d = StAddr;
          end
        end
        StAddr: begin
          state_d = StData;
        end
        StData: begin
          if (rom_dur == '0) begin
            // A zero duration marks the end of the song.
            end_song = 1'b1;
          end else begin
            note_d  = rom_note;
            dur_d   = rom_dur;
            state_d = StLoad;
          end
        end
        StLoad: begin
          state_d = StWaitDone;
        end
        StWaitDone: begin
          if (note_done || pending_q) begin
            if (index_q == LastIdx) begin
              end_song = 1'b1;
            end else if (play) begin
              index_d   = index_q + 1'b1;
              pending_d = 1'b0;
              state_d   = StAddr;
            end else begin
              // Hold the completion until play returns.
              pending_d = 1'b1;
            end
          end
        end
        default: begin
          state_d = StIdle;
        end
      endcase

      if (end_song) begin
        song_done_d = 1'b1;
        index_d     = '0;
        pending_d   = 1'b0;
`ifdef SONG_LOOP_EN
        state_d     = play ? StAddr : StIdle;
`else
        state_d     = StIdle;
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      index_q     <= '0;
      song_q      <= '0;
      pending_q   <= 1'b0;
      note_q      <= '0;
      dur_q       <= '0;
      song_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      index_q     <= index_d;
      song_q      <= song_d;
      pending_q   <= pending_d;
      note_q      <= note_d;
      dur_q       <= dur_d;
      song_done_q <= song_done_d;
    end
  end

  assign rom_addr         = {song_q, index_q};
  assign note_to_load     = note_q;
  assign duration_to_load = dur_q;
  assign load_new_note    = (state_q == StLoad);
  assign song_done        = song_done_q;

endmodule

// File: tb/tb_song_sequencer.sv
module tb_song_sequencer;

  logic        clk;
  logic        reset;
  logic        play;
  logic [1:0]  song;
  logic        note_done;
  logic [6:0]  rom_addr;
  logic [11:0] rom_data;
  logic [5:0]  note_to_load;
  logic [5:0]  duration_to_load;
  logic        load_new_note;
  logic        song_done;

  logic [11:0] rom_mem [128];
  logic [11:0] exp_q [$];
  int          checks;
  int          errors;
  int          load_cnt;
  int          done_cnt;
  int          load_mark;
  int          done_mark;

  song_sequencer dut (
    .clk              (clk),
    .reset            (reset),
    .play             (play),
    .song             (song),
    .note_done        (note_done),
    .rom_addr         (rom_addr),
    .rom_data         (rom_data),
    .note_to_load     (note_to_load),
    .duration_to_load (duration_to_load),
    .load_new_note    (load_new_note),
    .song_done        (song_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External ROM with a synchronous 1-cycle read.
  always @(posedge clk) rom_data <= rom_mem[rom_addr];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and sample 1 time unit later; every load strobe is scored here.
  task automatic tick();
    logic [11:0] e;
    @(posedge clk);
    #1;
    if (load_new_note || song_done) check("strobe_exclusive", load_new_note && song_done, 0);
    if (song_done) done_cnt++;
    if (load_new_note) begin
      load_cnt++;
      check("load_expected", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("note_to_load", note_to_load, e[11:6]);
        check("duration_to_load", duration_to_load, e[5:0]);
      end
    end
  endtask

  task automatic wait_load(input string tag, input int exp_cycles);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!load_new_note && n < 20);
    check(tag, n, exp_cycles);
  endtask

  task automatic ack_and_wait(input string tag, input int exp_cycles);
    int n;
    note_done = 1'b1;
    tick();
    note_done = 1'b0;
    n = 1;
    while (!load_new_note && n < 20) begin
      tick();
      n++;
    end
    check(tag, n, exp_cycles);
  endtask

  initial begin
    int n;
    checks    = 0;
    errors    = 0;
    load_cnt  = 0;
    done_cnt  = 0;
    reset     = 1'b1;
    play      = 1'b0;
    song      = 2'd0;
    note_done = 1'b0;

    for (int i = 0; i < 128; i++) rom_mem[i] = 12'h000;
    for (int i = 0; i < 32; i++) rom_mem[i] = {6'(i + 1), 6'((i % 5) + 1)};
    rom_mem[32] = {6'd10, 6'd4};
    rom_mem[33] = {6'd20, 6'd8};
    rom_mem[34] = {6'd7,  6'd0};
    rom_mem[64] = {6'd33, 6'd5};
    rom_mem[65] = {6'd34, 6'd6};

    // Reset state.
    repeat (3) tick();
    check("rst_load", load_new_note, 0);
    check("rst_song_done", song_done, 0);
    check("rst_note", note_to_load, 0);
    check("rst_dur", duration_to_load, 0);
    check("rst_addr", rom_addr, 0);
    reset = 1'b0;

    // First note of song 1.
    song = 2'd1;
    tick();
    check("t1_addr", rom_addr, 7'h20);
    exp_q.push_back(rom_mem[32]);
    play = 1'b1;
    wait_load("t1_latency", 3);
    tick();
    check("t1_strobe_width", load_new_note, 0);
    check("t1_note_held", note_to_load, 10);

    // Second note, then end marker.
    exp_q.push_back(rom_mem[33]);
    ack_and_wait("t2_latency", 3);
    repeat (2) tick();
    done_mark = done_cnt;
    load_mark = load_cnt;
    note_done = 1'b1;
    tick();
    note_done = 1'b0;
    play = 1'b0;
    n = 1;
    while (!song_done && n < 20) begin
      tick();
      n++;
    end
    check("t2_done_latency", n, 3);
    check("t2_done_count", done_cnt - done_mark, 1);
    check("t2_no_load", load_cnt - load_mark, 0);
    tick();
    check("t2_done_width", song_done, 0);
    check("t2_idle_index0", rom_addr, 7'h20);

    // Full 32-entry song.
    song = 2'd0;
    tick();
    load_mark = load_cnt;
    done_mark = done_cnt;
    for (int i = 0; i < 32; i++) begin
      exp_q.push_back(rom_mem[i]);
      if (i == 0) begin
        play = 1'b1;
        wait_load("t3_first_latency", 3);
      end else begin
        ack_and_wait("t3_latency", 3);
      end
      tick();
    end
    check("t3_load_count", load_cnt - load_mark, 32);
    check("t3_no_early_done", done_cnt - done_mark, 0);
    note_done = 1'b1;
    tick();
    note_done = 1'b0;
    play = 1'b0;
    check("t3_song_done", song_done, 1);
    tick();
    check("t3_done_width", song_done, 0);
    check("t3_idle_addr", rom_addr, 7'h00);
    check("t3_done_count", done_cnt - done_mark, 1);

    // Pause in WAIT_DONE, completion remembered.
    song = 2'd1;
    tick();
    exp_q.push_back(rom_mem[32]);
    play = 1'b1;
    wait_load("t4_first_latency", 3);
    tick();
    play = 1'b0;
    tick();
    load_mark = load_cnt;
    note_done = 1'b1;
    tick();
    note_done = 1'b0;
    repeat (5) tick();
    check("t4_no_fetch", load_cnt - load_mark, 0);
    check("t4_index_held", rom_addr, 7'h20);
    exp_q.push_back(rom_mem[33]);
    play = 1'b1;
    wait_load("t4_resume_latency", 3);
    repeat (5) tick();
    check("t4_single_advance", load_cnt - load_mark, 1);
    check("t4_addr_idx1", rom_addr, 7'h21);

    // Song change with a simultaneous note_done.
    done_mark = done_cnt;
    load_mark = load_cnt;
    exp_q.push_back(rom_mem[64]);
    song = 2'd2;
    note_done = 1'b1;
    tick();
    note_done = 1'b0;
    check("t5_addr", rom_addr, 7'h40);
    wait_load("t5_latency", 2);
    repeat (3) tick();
    check("t5_no_song_done", done_cnt - done_mark, 0);
    check("t5_one_load", load_cnt - load_mark, 1);

    // Reset while in LOAD.
    exp_q.push_back(rom_mem[65]);
    ack_and_wait("t6_latency", 3);
    reset = 1'b1;
    tick();
    check("t6_rst_load", load_new_note, 0);
    check("t6_rst_song_done", song_done, 0);
    check("t6_rst_note", note_to_load, 0);
    check("t6_rst_dur", duration_to_load, 0);
    check("t6_rst_addr", rom_addr, 7'h00);
    reset = 1'b0;
    exp_q.push_back(rom_mem[64]);
    tick();
    check("t6_restart_addr", rom_addr, 7'h40);
    wait_load("t6_restart_latency", 2);
    check("t6_no_song_done", done_cnt - done_mark, 0);
    check("t6_queue_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
